// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_unit
// Brief    : MIPS conditional-branch comparator with a PC-indexed BHT of
//            2-bit saturating counters, mispredict flagging and saturating
//            branch / mispredict statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              res_valid,
  input  logic              res_stall,
  input  logic [PC_W-1:0]   res_pc,
  input  logic              res_pred_taken,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  input  logic [2:0]        Branch,
  output logic              Branch_ok,
  output logic              mispredict,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] c_BR_NONE = 3'b000;
  localparam logic [2:0] c_BR_BEQ  = 3'b001;
  localparam logic [2:0] c_BR_BNE  = 3'b010;
  localparam logic [2:0] c_BR_BGEZ = 3'b011;
  localparam logic [2:0] c_BR_BGTZ = 3'b100;
  localparam logic [2:0] c_BR_BLEZ = 3'b101;
  localparam logic [2:0] c_BR_BLTZ = 3'b110;
  localparam logic [2:0] c_BR_RSVD = 3'b111;

  localparam logic [1:0] c_CTR_RESET = 2'b01;

  logic [1:0]       r_bht [BHT_DEPTH];
  logic [CNT_W-1:0] r_stat_branches;
  logic [CNT_W-1:0] r_stat_mispredicts;

  logic [IDX_W-1:0] w_lookup_idx;
  logic [IDX_W-1:0] w_res_idx;
  logic             w_a_neg;
  logic             w_a_zero;
  logic             w_valid_res;
  logic             w_unused_pc_bits;

  // Word-aligned table index: byte offset bits are dropped.
  assign w_lookup_idx = if_pc[IDX_W+1:2];
  assign w_res_idx    = res_pc[IDX_W+1:2];

  // Upper PC bits and the byte offset do not take part in indexing.
  assign w_unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                              res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

  assign w_a_neg  = busA[DATA_W-1];
  assign w_a_zero = (busA == '0);

  // Branch condition evaluation, independent of res_valid.
  always_comb begin
    Branch_ok = 1'b0;
    case (Branch)
      c_BR_BEQ:  Branch_ok = (busA == busB);
      c_BR_BNE:  Branch_ok = (busA != busB);
      c_BR_BGEZ: Branch_ok = ~w_a_neg;
      c_BR_BGTZ: Branch_ok = ~w_a_neg & ~w_a_zero;
      c_BR_BLEZ: Branch_ok = w_a_neg | w_a_zero;
      c_BR_BLTZ: Branch_ok = w_a_neg;
      c_BR_NONE: Branch_ok = 1'b0;
      c_BR_RSVD: Branch_ok = 1'b0;
      default:   Branch_ok = 1'b0;
    endcase
  end

  // A resolve event counts only for real branch encodings while not stalled.
  assign w_valid_res = res_valid & ~res_stall &
                       (Branch != c_BR_NONE) & (Branch != c_BR_RSVD);

  assign mispredict = w_valid_res & (Branch_ok != res_pred_taken);

  // Prediction is the counter MSB, read without bypassing a same-cycle update.
  assign if_pred_taken = r_bht[w_lookup_idx][1];

  genvar gi;
  generate
    for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
      // Per-entry 2-bit saturating counter, moved toward the resolved outcome.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_bht[gi] <= c_CTR_RESET;
        end else if (w_valid_res && (w_res_idx == IDX_W'(gi))) begin
          if (Branch_ok) begin
            if (r_bht[gi] != 2'b11) r_bht[gi] <= r_bht[gi] + 2'b01;
          end else begin
            if (r_bht[gi] != 2'b00) r_bht[gi] <= r_bht[gi] - 2'b01;
          end
        end
      end
    end
  endgenerate

  // Statistics counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_valid_res) begin
      if (r_stat_branches != '1) r_stat_branches <= r_stat_branches + 1'b1;
      if (mispredict && (r_stat_mispredicts != '1))
        r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_unit
// Brief    : Directed self-checking bench for branch_predict_unit
//            (CNT_W=4 so statistics saturation is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [31:0]      if_pc;
  logic             if_pred_taken;
  logic             res_valid;
  logic             res_stall;
  logic [31:0]      res_pc;
  logic             res_pred_taken;
  logic [31:0]      busA;
  logic [31:0]      busB;
  logic [2:0]       Branch;
  logic             Branch_ok;
  logic             mispredict;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;

  int n_checks;
  int n_pass;

  branch_predict_unit #(
    .DATA_W   (32),
    .PC_W     (32),
    .BHT_DEPTH(16),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_pc           (if_pc),
    .if_pred_taken   (if_pred_taken),
    .res_valid       (res_valid),
    .res_stall       (res_stall),
    .res_pc          (res_pc),
    .res_pred_taken  (res_pred_taken),
    .busA            (busA),
    .busB            (busB),
    .Branch          (Branch),
    .Branch_ok       (Branch_ok),
    .mispredict      (mispredict),
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [2:0] br, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic pt);
    Branch         = br;
    busA           = a;
    busB           = b;
    res_pc         = pc;
    res_pred_taken = pt;
    res_valid      = 1'b1;
    res_stall      = 1'b0;
  endtask

  task automatic idle();
    res_valid = 1'b0;
    res_stall = 1'b0;
    Branch    = 3'b000;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    if_pc = 32'h0040_0000;
    res_pc = '0;
    res_pred_taken = 1'b0;
    busA = '0;
    busB = '0;
    idle();

    // Reset state
    #12;
    chk("reset_pred", {31'd0, if_pred_taken}, 32'd0);
    chk("reset_stat_br", {28'd0, stat_branches}, 32'd0);
    chk("reset_stat_mp", {28'd0, stat_mispredicts}, 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // BEQ taken, predicted not-taken: entry 4 01 -> 10
    resolve(3'b001, 32'h5, 32'h5, 32'h0040_0010, 1'b0);
    #1;
    chk("beq_ok", {31'd0, Branch_ok}, 32'd1);
    chk("beq_mispredict", {31'd0, mispredict}, 32'd1);
    tick();
    idle();
    if_pc = 32'h0040_0010;
    #1;
    chk("beq_pred_after", {31'd0, if_pred_taken}, 32'd1);
    chk("beq_stat_br", {28'd0, stat_branches}, 32'd1);
    chk("beq_stat_mp", {28'd0, stat_mispredicts}, 32'd1);

    // Sign cases with res_valid=0
    Branch = 3'b100; busA = 32'h0;         #1 chk("bgtz_zero", {31'd0, Branch_ok}, 32'd0);
    Branch = 3'b101; busA = 32'h0;         #1 chk("blez_zero", {31'd0, Branch_ok}, 32'd1);
    Branch = 3'b110; busA = 32'h8000_0000; #1 chk("bltz_min", {31'd0, Branch_ok}, 32'd1);
    Branch = 3'b011; busA = 32'h7FFF_FFFF; #1 chk("bgez_max", {31'd0, Branch_ok}, 32'd1);
    Branch = 3'b011; busA = 32'h8000_0000; #1 chk("bgez_neg", {31'd0, Branch_ok}, 32'd0);
    Branch = 3'b100; busA = 32'h0000_0001; #1 chk("bgtz_one", {31'd0, Branch_ok}, 32'd1);
    Branch = 3'b010; busA = 32'h1234_5678; busB = 32'h1234_5678;
    #1 chk("bne_equal", {31'd0, Branch_ok}, 32'd0);
    chk("novalid_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    chk("novalid_stat_br", {28'd0, stat_branches}, 32'd1);
    chk("novalid_stat_mp", {28'd0, stat_mispredicts}, 32'd1);

    // Saturation of entry 1 (pc 0x00400044): 4 taken BNE -> 11
    if_pc = 32'h0040_0044;
    for (int i = 0; i < 4; i++) begin
      resolve(3'b010, 32'h1, 32'h2, 32'h0040_0044, 1'b1);
      tick();
    end
    idle();
    #1;
    chk("sat_pred_taken", {31'd0, if_pred_taken}, 32'd1);
    chk("sat_stat_br", {28'd0, stat_branches}, 32'd5);
    chk("sat_stat_mp", {28'd0, stat_mispredicts}, 32'd1);
    // One not-taken: 11 -> 10, prediction stays taken
    resolve(3'b010, 32'h3, 32'h3, 32'h0040_0044, 1'b1);
    #1 chk("nt_mispredict", {31'd0, mispredict}, 32'd1);
    tick();
    idle();
    #1 chk("after_one_nt_pred", {31'd0, if_pred_taken}, 32'd1);
    // Second not-taken: 10 -> 01, prediction flips (proves it was saturated at 11)
    resolve(3'b010, 32'h3, 32'h3, 32'h0040_0044, 1'b1);
    tick();
    idle();
    #1 chk("after_two_nt_pred", {31'd0, if_pred_taken}, 32'd0);
    chk("nt_stat_br", {28'd0, stat_branches}, 32'd7);
    chk("nt_stat_mp", {28'd0, stat_mispredicts}, 32'd3);

    // Stall: taken BEQ suppressed
    resolve(3'b001, 32'h9, 32'h9, 32'h0040_0044, 1'b0);
    res_stall = 1'b1;
    #1 chk("stall_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    idle();
    #1 chk("stall_pred", {31'd0, if_pred_taken}, 32'd0);
    chk("stall_stat_br", {28'd0, stat_branches}, 32'd7);
    // Reserved encoding with valid: no decrement, no count
    resolve(3'b111, 32'h9, 32'h9, 32'h0040_0044, 1'b1);
    #1 chk("rsvd_ok", {31'd0, Branch_ok}, 32'd0);
    chk("rsvd_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    idle();
    #1 chk("rsvd_stat_br", {28'd0, stat_branches}, 32'd7);
    chk("rsvd_stat_mp", {28'd0, stat_mispredicts}, 32'd3);
    // Entry still 01: one taken makes it 10 (would be 01 if it had dropped to 00)
    resolve(3'b001, 32'h9, 32'h9, 32'h0040_0044, 1'b0);
    tick();
    idle();
    #1 chk("rsvd_entry_kept", {31'd0, if_pred_taken}, 32'd1);

    // Same-index lookup and update at 0x00400020 (entry 8, 01)
    if_pc = 32'h0040_0020;
    resolve(3'b001, 32'h7, 32'h7, 32'h0040_0020, 1'b0);
    #1 chk("same_idx_old", {31'd0, if_pred_taken}, 32'd0);
    tick();
    chk("same_idx_new", {31'd0, if_pred_taken}, 32'd1);
    idle();
    #1 chk("same_idx_stat_br", {28'd0, stat_branches}, 32'd9);
    chk("same_idx_stat_mp", {28'd0, stat_mispredicts}, 32'd5);

    // Statistics saturation: 11 more mispredicting events -> 20 total
    for (int i = 0; i < 11; i++) begin
      resolve(3'b001, 32'h1, 32'h1, 32'h0040_0030, 1'b0);
      tick();
    end
    idle();
    #1 chk("stat_br_sat", {28'd0, stat_branches}, 32'd15);
    chk("stat_mp_sat", {28'd0, stat_mispredicts}, 32'd15);

    // Asynchronous reset mid-cycle, with a valid event pending
    resolve(3'b001, 32'h2, 32'h2, 32'h0040_0010, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_stat_br", {28'd0, stat_branches}, 32'd0);
    chk("async_stat_mp", {28'd0, stat_mispredicts}, 32'd0);
    chk("async_pred_20", {31'd0, if_pred_taken}, 32'd0);
    if_pc = 32'h0040_0010;
    #1 chk("async_pred_10", {31'd0, if_pred_taken}, 32'd0);
    chk("async_comb_ok", {31'd0, Branch_ok}, 32'd1);
    tick();
    chk("reset_hold_stat", {28'd0, stat_branches}, 32'd0);
    chk("reset_hold_pred", {31'd0, if_pred_taken}, 32'd0);
    // Release: first edge with rst_n=1 applies the pending event
    #2 rst_n = 1'b1;
    tick();
    idle();
    #1 chk("release_stat_br", {28'd0, stat_branches}, 32'd1);
    chk("release_pred", {31'd0, if_pred_taken}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor of the pipeline's combinational branch comparator.
- Resolves MIPS conditional branches (BEQ/BNE/BGEZ/BGTZ/BLEZ/BLTZ) in the ID/EX stage.
- Adds a PC-indexed branch history table (BHT) of 2-bit saturating counters that supplies a taken/not-taken prediction to IF.
- Flags mispredictions for pipeline flush and keeps saturating branch and mispredict statistics counters.

Parameters:
DATA_W, 32, width of compared operands busA/busB
PC_W, 32, width of program counters
BHT_DEPTH, 16, number of BHT entries (power of 2, >= 2)
IDX_W, log2(BHT_DEPTH), BHT index width (derived)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
if_pc  in  PC_W  fetch-stage PC for prediction lookup
if_pred_taken  out  1  prediction for if_pc (combinational)
res_valid  in  1  ID/EX holds a branch to resolve this cycle
res_stall  in  1  pipeline stall; suppresses update and counting
res_pc  in  PC_W  PC of the branch being resolved
res_pred_taken  in  1  prediction carried down the pipe with the branch
busA  in  DATA_W  first operand
busB  in  DATA_W  second operand
Branch  in  3  000 none, 001 BEQ, 010 BNE, 011 BGEZ, 100 BGTZ, 101 BLEZ, 110 BLTZ, 111 reserved
Branch_ok  out  1  branch condition true (combinational)
mispredict  out  1  resolved outcome differs from res_pred_taken (combinational)
stat_branches  out  CNT_W  count of resolved branches
stat_mispredicts  out  CNT_W  count of mispredictions

Behaviour:
- Index: idx(pc) = pc[IDX_W+1:2], word-aligned. Bits [1:0] are ignored.
- Branch_ok is combinational and independent of res_valid:
  - 001: busA == busB
  - 010: busA != busB
  - 011: busA[DATA_W-1] == 0
  - 100: busA[DATA_W-1] == 0 and busA != 0
  - 101: busA[DATA_W-1] == 1 or busA == 0
  - 110: busA[DATA_W-1] == 1
  - 000 and 111: 0
  - All sign tests use the MSB only. BEQ/BNE are full-width equality.
- Valid resolve event: res_valid=1, res_stall=0, Branch in 001..110.
- mispredict = valid resolve event and (Branch_ok != res_pred_taken). Otherwise 0.
- if_pred_taken = bht[idx(if_pc)][1]. Combinational read, no latency.
- BHT update at the rising edge of a valid resolve event, applied to bht[idx(res_pc)]:
  - taken: counter increments, saturating at 11
  - not taken: counter decrements, saturating at 00
  - States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- No update occurs when res_valid=0, res_stall=1, or Branch is 000/111.
- Same-cycle lookup and update of the same index: if_pred_taken reflects the pre-update value. No bypass. The new value is visible from the next cycle.
- stat_branches increments by 1 on every valid resolve event.
- stat_mispredicts increments by 1 on every valid resolve event with mispredict=1.
- Both statistics counters saturate at all-ones and never wrap.
- Reset (async, rst_n=0):
  - all BHT entries = 01
  - stat_branches = 0, stat_mispredicts = 0
  - if_pred_taken therefore reads 0 during and after reset.
  - Combinational outputs follow their inputs throughout reset, but no state changes.
- Reset asserted mid-update: state is forced to reset values immediately. The coincident edge has no effect.
- Release of rst_n: the first state update occurs on the first rising clk edge with rst_n=1.

Test Plan:
- Reset, then if_pc=0x00400000 -> if_pred_taken=0; stats 0/0.
- BEQ with busA=busB=0x5, res_pred_taken=0, res_pc=0x00400010 -> Branch_ok=1, mispredict=1. After the edge: entry 4 = 10, if_pred_taken=1 at if_pc=0x00400010, stats 1/1.
- Sign cases: BGTZ busA=0 -> 0. BLEZ busA=0 -> 1. BLTZ busA=0x80000000 -> 1. BGEZ busA=0x7FFFFFFF -> 1. Run each with res_valid=0 -> no stat change.
- Saturation: 4 taken BNE at one PC -> counter 11. One not-taken -> 10, and the prediction stays 1. With CNT_W=4, 20 events -> stat_branches=15.
- Stall/reserved: res_stall=1 or Branch=111 with res_valid=1 -> mispredict=0, BHT and stats unchanged.
- Same index: lookup and update of 0x00400020 in the same cycle -> old prediction this cycle, new one next cycle. Pull rst_n low mid-run -> all entries 01 and stats 0 immediately, without waiting for clk.
